// File: rtl/usb_rx_timer.sv
// Bit/byte timing for the USB full-speed receive path: recovers bit timing
// from d_edge, shifts data bits, removes stuffed bits and flags whole bytes.
module usb_rx_timer #(
    parameter int unsigned CLKS_PER_BIT  = 8,
    parameter int unsigned SAMPLE_PT     = 3,
    parameter int unsigned BITS_PER_BYTE = 8,
    parameter int unsigned STUFF_RUN     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       d_orig,
    input  logic       eop,
    input  logic       rcving,
    output logic       shift_enable,
    output logic       byte_received,
    output logic       stuff_bit,
    output logic       stuff_error,
    output logic [3:0] bit_count
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned RW = $clog2(STUFF_RUN + 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    logic [RW-1:0] ones_run;

    logic sample;
    logic stuff_due;
    logic byte_done;

    always_comb begin
        sample       = (state != IDLE) && (clk_cnt == CW'(SAMPLE_PT));
        stuff_due    = (ones_run == RW'(STUFF_RUN));
        shift_enable = sample && (eop || !stuff_due);
        stuff_bit    = sample && !eop && stuff_due && !d_orig;
        stuff_error  = sample && !eop && stuff_due && d_orig;
        byte_done    = shift_enable && !eop && (bit_cnt == 4'(BITS_PER_BYTE - 1));
    end

    assign bit_count = bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            ones_run      <= '0;
            byte_received <= 1'b0;
        end else begin
            byte_received <= byte_done;
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    ones_run <= '0;
                    if (d_edge) begin
                        state   <= SYNC;
                        clk_cnt <= CW'(1);
                    end else begin
                        clk_cnt <= '0;
                    end
                end
                default: begin
                    // The edge cycle itself counts as 0, so a resync reloads 1.
                    if (d_edge)
                        clk_cnt <= CW'(1);
                    else if (clk_cnt == CW'(CLKS_PER_BIT - 1))
                        clk_cnt <= '0;
                    else
                        clk_cnt <= clk_cnt + CW'(1);

                    if (sample) begin
                        if (eop) begin
                            ones_run <= '0;
                            bit_cnt  <= '0;
                        end else if (stuff_due) begin
                            ones_run <= '0;
                        end else begin
                            ones_run <= d_orig ? ones_run + RW'(1) : '0;
                            bit_cnt  <= byte_done ? 4'd0 : bit_cnt + 4'd1;
                        end
                    end

                    if (state == SYNC) begin
                        state <= RUN;
                    end else if (!rcving) begin
                        state    <= IDLE;
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                        ones_run <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_timer.sv
// Self-checking bench for usb_rx_timer: directed scenarios plus randomized
// packets against a timestamp-based reference model.
module tb_usb_rx_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;
    localparam int BPB = 8;
    localparam int SR  = 6;

    logic       clk = 1'b0;
    logic       rst, d_edge, d_orig, eop, rcving;
    logic       shift_enable, byte_received, stuff_bit, stuff_error;
    logic [3:0] bit_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: bit timing as elapsed cycles since the last edge.
    bit m_active  = 0;
    int m_act_t   = 0;
    int m_last_e  = 0;
    int m_bits    = 0;
    int m_ones    = 0;
    bit m_byte    = 0;
    int t         = 0;

    usb_rx_timer #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_PT    (SP),
        .BITS_PER_BYTE(BPB),
        .STUFF_RUN    (SR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d_edge       (d_edge),
        .d_orig       (d_orig),
        .eop          (eop),
        .rcving       (rcving),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .stuff_bit    (stuff_bit),
        .stuff_error  (stuff_error),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check, then advance the model.
    task automatic cycle(input logic r, input logic de, input logic dor,
                         input logic eo, input logic rcv);
        bit smp, es, esb, ese, ebr, nb;
        int ebc;
        smp = 0;
        @(negedge clk);
        rst = r; d_edge = de; d_orig = dor; eop = eo; rcving = rcv;
        #1;
        if (r) begin
            m_active = 0; m_bits = 0; m_ones = 0; m_byte = 0;
            es = 0; esb = 0; ese = 0; ebc = 0; ebr = 0;
        end else begin
            smp = m_active && (((t - m_last_e) % CPB) == SP);
            es  = smp && (eo || m_ones != SR);
            esb = smp && !eo && m_ones == SR && !dor;
            ese = smp && !eo && m_ones == SR && dor;
            ebc = m_bits;
            ebr = m_byte;
        end
        check("shift_enable", shift_enable, es);
        check("stuff_bit", stuff_bit, esb);
        check("stuff_error", stuff_error, ese);
        check("byte_received", byte_received, ebr);
        check("bit_count", bit_count, ebc[7:0]);
        if (!r) begin
            nb = 0;
            if (smp) begin
                if (eo) begin
                    m_ones = 0; m_bits = 0;
                end else if (m_ones == SR) begin
                    m_ones = 0;
                end else begin
                    m_ones = dor ? m_ones + 1 : 0;
                    m_bits++;
                    if (m_bits == BPB) begin
                        m_bits = 0; nb = 1;
                    end
                end
            end
            m_byte = nb;
            if (m_active) begin
                if (t >= m_act_t + 2 && !rcv) begin
                    m_active = 0; m_bits = 0; m_ones = 0;
                end else if (de) begin
                    m_last_e = t;
                end
            end else if (de) begin
                m_active = 1; m_act_t = t; m_last_e = t;
            end
        end
        t++;
    endtask

    task automatic go_idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; d_edge = 1'b0; d_orig = 1'b0; eop = 1'b0; rcving = 1'b0;

        // Reset state
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 1);
        go_idle(3);

        // Plain byte of zeros: shifts every 8 cycles from edge+3, byte at 60
        for (int i = 0; i < 64; i++) begin
            cycle(0, i == 0, 0, 0, i != 0);
            check("t2_shift", shift_enable, (i >= 3 && i <= 59 && i % 8 == 3));
            check("t2_byte", byte_received, (i == 60));
            if (i == 60) check("t2_bc_wrap", bit_count, 0);
        end
        go_idle(4);

        // Resync by a second edge at cycle 10
        for (int i = 0; i < 24; i++) begin
            cycle(0, i == 0 || i == 10, 0, 0, i != 0);
            check("t3_shift", shift_enable, (i == 3 || i == 13 || i == 21));
        end
        go_idle(4);

        // Six 1s then a stuffed 0 on the 7th sample
        for (int i = 0; i < 62; i++) begin
            cycle(0, i == 0, i <= 43, 0, i != 0);
            if (i == 51) begin
                check("t4_shift", shift_enable, 0);
                check("t4_stuff", stuff_bit, 1);
                check("t4_bc", bit_count, 6);
            end
            if (i == 59) check("t4_next_shift", shift_enable, 1);
        end
        go_idle(4);

        // Six 1s then another 1: stuff error
        for (int i = 0; i < 62; i++) begin
            cycle(0, i == 0, 1, 0, i != 0);
            if (i == 51) begin
                check("t5_err", stuff_error, 1);
                check("t5_shift", shift_enable, 0);
            end
            if (i == 52) check("t5_err_width", stuff_error, 0);
            if (i == 59) begin
                check("t5_after_shift", shift_enable, 1);
                check("t5_bc", bit_count, 6);
            end
        end
        go_idle(4);

        // rcving drops after 3 bits; restart on later edge
        for (int i = 0; i < 48; i++) begin
            cycle(0, i == 0 || i == 40, i[0], 0, (i >= 1 && i < 22) || i >= 41);
            if (i == 23) check("t6_bc_idle", bit_count, 0);
            if (i > 22 && i < 40) check("t6_no_shift", shift_enable, 0);
            if (i == 43) check("t6_restart", shift_enable, 1);
        end
        go_idle(4);

        // Reset mid-packet, no restart until a new edge
        for (int i = 0; i < 30; i++) cycle(0, i == 0, $urandom_range(0, 1), 0, i != 0);
        cycle(1, 1, 1, 0, 1);
        check("t1_bc", bit_count, 0);
        cycle(1, 1, 1, 1, 1);
        cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 1, 0, 1);
            check("t1_quiet", shift_enable, 0);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(0, i == 0, 0, 0, 1);
            check("t1_restart", shift_enable, (i == 3));
        end
        go_idle(4);

        // Randomized packets with resyncs, stuffing, EOPs and resets
        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(20, 200));
            cycle(0, 1, 1, 0, 0);
            for (int i = 1; i < len; i++) begin
                cycle($urandom_range(0, 299) == 0,
                      $urandom_range(0, 11) == 0,
                      $urandom_range(0, 7) != 0,
                      $urandom_range(0, 59) == 0,
                      $urandom_range(0, 99) != 0);
            end
            for (int i = 0; i < int'($urandom_range(2, 6)); i++)
                cycle(0, $urandom_range(0, 9) == 0, $urandom_range(0, 1), 0, 0);
            go_idle(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
